// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
// Captures the decoder control word and operand data and presents them to EX.
// Raises a combinational load-use stall against the instruction held in EX.
// Loads bubbles on stall or flush. Freezes on memory hold, and a flush seen
// during a hold stays pending until the hold ends.
// Optional: define ID_EX_PERF_EN to add the stall_cnt/flush_cnt counters.
module id_ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
`ifdef ID_EX_PERF_EN
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt,
`endif
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [1:0]    id_pcsrc,
  input  logic          id_branch,
  input  logic          id_regwrite,
  input  logic [1:0]    id_regdst,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic [1:0]    id_memtoreg,
  input  logic          id_alusrc1,
  input  logic          id_alusrc2,
  input  logic [3:0]    id_aluop,
  input  logic          id_irq,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic [AW-1:0] id_rd_addr,
  input  logic [4:0]    id_shamt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm_ext,
  input  logic [DW-1:0] id_pc_plus4,
  input  logic          flush_i,
  input  logic          hold_i,
  output logic          stall_o,
  output logic          ex_valid,
  output logic [1:0]    ex_pcsrc,
  output logic          ex_branch,
  output logic          ex_regwrite,
  output logic [1:0]    ex_regdst,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic [1:0]    ex_memtoreg,
  output logic          ex_alusrc1,
  output logic          ex_alusrc2,
  output logic [3:0]    ex_aluop,
  output logic          ex_irq,
  output logic [AW-1:0] ex_rs_addr,
  output logic [AW-1:0] ex_rt_addr,
  output logic [AW-1:0] ex_rd_addr,
  output logic [4:0]    ex_shamt,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm_ext,
  output logic [DW-1:0] ex_pc_plus4
);

  typedef struct packed {
    logic          valid;
    logic [1:0]    pcsrc;
    logic          branch;
    logic          regwrite;
    logic [1:0]    regdst;
    logic          memread;
    logic          memwrite;
    logic [1:0]    memtoreg;
    logic          alusrc1;
    logic          alusrc2;
    logic [3:0]    aluop;
    logic          irq;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [AW-1:0] rd_addr;
    logic [4:0]    shamt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] pc_plus4;
  } ex_word_t;

  ex_word_t ex_q, ex_d, id_word;
  logic     pend_q, pend_d;
  logic     hz, do_flush, do_stall;

  // Assemble the incoming word; an empty ID slot carries no control effects
  always_comb begin
    id_word          = '0;
    id_word.valid    = id_valid;
    id_word.rs_addr  = id_rs_addr;
    id_word.rt_addr  = id_rt_addr;
    id_word.rd_addr  = id_rd_addr;
    id_word.shamt    = id_shamt;
    id_word.rs_data  = id_rs_data;
    id_word.rt_data  = id_rt_data;
    id_word.imm_ext  = id_imm_ext;
    id_word.pc_plus4 = id_pc_plus4;
    if (id_valid) begin
      id_word.pcsrc    = id_pcsrc;
      id_word.branch   = id_branch;
      id_word.regwrite = id_regwrite;
      id_word.regdst   = id_regdst;
      id_word.memread  = id_memread;
      id_word.memwrite = id_memwrite;
      id_word.memtoreg = id_memtoreg;
      id_word.alusrc1  = id_alusrc1;
      id_word.alusrc2  = id_alusrc2;
      id_word.aluop    = id_aluop;
      id_word.irq      = id_irq;
    end
  end

  // Load-use hazard and priority decode: hold > flush/pending > hazard > load
  always_comb begin
    hz = ex_q.valid & ex_q.memread & (ex_q.rt_addr != '0) & id_valid &
         ((id_use_rs & (id_rs_addr == ex_q.rt_addr)) |
          (id_use_rt & (id_rt_addr == ex_q.rt_addr)));
    stall_o  = hz & ~flush_i & ~pend_q & ~hold_i;
    do_flush = ~hold_i & (flush_i | pend_q);
    do_stall = ~hold_i & ~(flush_i | pend_q) & hz;
    ex_d     = ex_q;
    pend_d   = pend_q;
    if (hold_i) begin
      if (flush_i) pend_d = 1'b1;
    end else if (do_flush) begin
      ex_d   = '0;
      pend_d = 1'b0;
    end else if (do_stall) begin
      ex_d = '0;
    end else begin
      ex_d = id_word;
    end
  end

  // Pipeline register and pending-flush flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      pend_q <= pend_d;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Event counters; both are gated off by hold through do_stall/do_flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (do_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (do_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  assign ex_valid    = ex_q.valid;
  assign ex_pcsrc    = ex_q.pcsrc;
  assign ex_branch   = ex_q.branch;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_regdst   = ex_q.regdst;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_alusrc1  = ex_q.alusrc1;
  assign ex_alusrc2  = ex_q.alusrc2;
  assign ex_aluop    = ex_q.aluop;
  assign ex_irq      = ex_q.irq;
  assign ex_rs_addr  = ex_q.rs_addr;
  assign ex_rt_addr  = ex_q.rt_addr;
  assign ex_rd_addr  = ex_q.rd_addr;
  assign ex_shamt    = ex_q.shamt;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm_ext  = ex_q.imm_ext;
  assign ex_pc_plus4 = ex_q.pc_plus4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic, all compared against a field-level reference model of the stage.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [1:0]  pcsrc;
    logic        branch;
    logic        regwrite;
    logic [1:0]  regdst;
    logic        memread;
    logic        memwrite;
    logic [1:0]  memtoreg;
    logic        alusrc1;
    logic        alusrc2;
    logic [3:0]  aluop;
    logic        irq;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  shamt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
  } word_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  word_t in_w;
  logic  use_rs, use_rt, flush, hold;
  logic  stall_o;
  word_t out_w;

  int checks = 0;
  int failures = 0;

  // reference model state
  word_t m_ex;
  logic  m_pend;
  logic [31:0] m_stalls, m_flushes;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .AW(5)) dut (
`ifdef ID_EX_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .clk(clk), .rst_n(rst_n),
    .id_valid(in_w.valid), .id_pcsrc(in_w.pcsrc), .id_branch(in_w.branch),
    .id_regwrite(in_w.regwrite), .id_regdst(in_w.regdst),
    .id_memread(in_w.memread), .id_memwrite(in_w.memwrite),
    .id_memtoreg(in_w.memtoreg), .id_alusrc1(in_w.alusrc1),
    .id_alusrc2(in_w.alusrc2), .id_aluop(in_w.aluop), .id_irq(in_w.irq),
    .id_use_rs(use_rs), .id_use_rt(use_rt),
    .id_rs_addr(in_w.rs_addr), .id_rt_addr(in_w.rt_addr), .id_rd_addr(in_w.rd_addr),
    .id_shamt(in_w.shamt), .id_rs_data(in_w.rs_data), .id_rt_data(in_w.rt_data),
    .id_imm_ext(in_w.imm_ext), .id_pc_plus4(in_w.pc_plus4),
    .flush_i(flush), .hold_i(hold), .stall_o(stall_o),
    .ex_valid(out_w.valid), .ex_pcsrc(out_w.pcsrc), .ex_branch(out_w.branch),
    .ex_regwrite(out_w.regwrite), .ex_regdst(out_w.regdst),
    .ex_memread(out_w.memread), .ex_memwrite(out_w.memwrite),
    .ex_memtoreg(out_w.memtoreg), .ex_alusrc1(out_w.alusrc1),
    .ex_alusrc2(out_w.alusrc2), .ex_aluop(out_w.aluop), .ex_irq(out_w.irq),
    .ex_rs_addr(out_w.rs_addr), .ex_rt_addr(out_w.rt_addr), .ex_rd_addr(out_w.rd_addr),
    .ex_shamt(out_w.shamt), .ex_rs_data(out_w.rs_data), .ex_rt_data(out_w.rt_data),
    .ex_imm_ext(out_w.imm_ext), .ex_pc_plus4(out_w.pc_plus4)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_hz();
    return m_ex.valid && m_ex.memread && (m_ex.rt_addr != 5'd0) && in_w.valid &&
           ((use_rs && in_w.rs_addr == m_ex.rt_addr) ||
            (use_rt && in_w.rt_addr == m_ex.rt_addr));
  endfunction

  // what EX should hold after a normal load of the ID slot
  function automatic word_t model_load();
    word_t w;
    w = in_w;
    if (!in_w.valid) begin
      w.pcsrc = 0; w.branch = 0; w.regwrite = 0; w.regdst = 0;
      w.memread = 0; w.memwrite = 0; w.memtoreg = 0; w.alusrc1 = 0;
      w.alusrc2 = 0; w.aluop = 0; w.irq = 0;
    end
    return w;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_pend = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ex"}, out_w, m_ex);
`ifdef ID_EX_PERF_EN
    check({tag, "_stall_cnt"}, stall_cnt, m_stalls);
    check({tag, "_flush_cnt"}, flush_cnt, m_flushes);
`endif
  endtask

  // called shortly after a rising edge with inputs already applied
  task automatic cycle(input string tag);
    logic hz;
    #1;
    hz = model_hz();
    check({tag, "_stall"}, stall_o, hz && !flush && !m_pend && !hold);
    @(posedge clk);
    if (hold) begin
      if (flush) m_pend = 1;
    end else if (flush || m_pend) begin
      m_ex = '0; m_pend = 0; m_flushes++;
    end else if (hz) begin
      m_ex = '0; m_stalls++;
    end else begin
      m_ex = model_load();
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_in();
    in_w = '0; use_rs = 0; use_rt = 0; flush = 0; hold = 0;
  endtask

  task automatic set_lw(input logic [4:0] rt);
    idle_in();
    in_w.valid = 1; in_w.memread = 1; in_w.regwrite = 1; in_w.alusrc2 = 1;
    in_w.memtoreg = 2'b01; in_w.rs_addr = 5'd1; in_w.rt_addr = rt;
    in_w.imm_ext = 32'h10; in_w.pc_plus4 = 32'h104; use_rs = 1;
  endtask

  task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    idle_in();
    in_w.valid = 1; in_w.regwrite = 1; in_w.regdst = 2'b01; in_w.aluop = 4'b0010;
    in_w.rs_addr = rs; in_w.rt_addr = rt; in_w.rd_addr = rd;
    in_w.rs_data = 32'd5; in_w.rt_data = 32'd7; in_w.pc_plus4 = 32'h108;
    use_rs = 1; use_rt = 1;
  endtask

  task automatic randomize_in();
    in_w.valid    = ($urandom % 8) != 0;
    in_w.pcsrc    = 2'($urandom);  in_w.branch  = 1'($urandom);
    in_w.regwrite = 1'($urandom);  in_w.regdst  = 2'($urandom);
    in_w.memread  = ($urandom % 3) == 0;
    in_w.memwrite = 1'($urandom);  in_w.memtoreg = 2'($urandom);
    in_w.alusrc1  = 1'($urandom);  in_w.alusrc2 = 1'($urandom);
    in_w.aluop    = 4'($urandom);  in_w.irq     = ($urandom % 16) == 0;
    in_w.rs_addr  = 5'($urandom_range(0, 3));
    in_w.rt_addr  = 5'($urandom_range(0, 3));
    in_w.rd_addr  = 5'($urandom);  in_w.shamt   = 5'($urandom);
    in_w.rs_data  = $urandom;      in_w.rt_data = $urandom;
    in_w.imm_ext  = $urandom;      in_w.pc_plus4 = $urandom;
    use_rs = 1'($urandom); use_rt = 1'($urandom);
    flush  = ($urandom % 10) == 0;
    hold   = ($urandom % 7) == 0;
  endtask

  initial begin
    word_t frozen;
    idle_in();
    model_reset();
    #12;
    check_outputs("reset");
    check("reset_stall", stall_o, 1'b0);
    rst_n = 1;

    // asynchronous reset mid-cycle with a valid instruction in flight
    @(posedge clk); #1;
    set_lw(5'd8);
    cycle("pre_rst");
    set_add(5'd8, 5'd1, 5'd9);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("rst_async_ex", out_w, '0);
    check("rst_async_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;

    // pass-through: add $3,$1,$2
    set_add(5'd1, 5'd2, 5'd3);
    cycle("pass");
    check("pass_rs_data", out_w.rs_data, 32'd5);
    check("pass_rt_data", out_w.rt_data, 32'd7);
    check("pass_aluop", out_w.aluop, 4'b0010);
    check("pass_regdst", out_w.regdst, 2'b01);
    check("pass_regwrite", out_w.regwrite, 1'b1);
    check("pass_valid", out_w.valid, 1'b1);

    // load-use: lw $8 then add $9,$8,$1
    set_lw(5'd8);
    cycle("lu_lw");
    set_add(5'd8, 5'd1, 5'd9);
    #1 check("lu_stall_hi", stall_o, 1'b1);
    cycle("lu_stall");
    check("lu_bubble_valid", out_w.valid, 1'b0);
    check("lu_bubble_regwrite", out_w.regwrite, 1'b0);
    #1 check("lu_stall_lo", stall_o, 1'b0);
    cycle("lu_add");
    check("lu_add_valid", out_w.valid, 1'b1);
    check("lu_add_rs", out_w.rs_addr, 5'd8);

    // load into $0 never stalls
    set_lw(5'd0);
    cycle("lu0_lw");
    set_add(5'd0, 5'd1, 5'd9);
    #1 check("lu0_stall", stall_o, 1'b0);
    cycle("lu0_add");
    check("lu0_add_valid", out_w.valid, 1'b1);

    // flush wins over stall
    set_lw(5'd8);
    cycle("fs_lw");
    set_add(5'd8, 5'd1, 5'd9);
    flush = 1;
    #1 check("fs_stall", stall_o, 1'b0);
    cycle("fs_flush");
    check("fs_bubble", out_w, '0);

    // hold for 3 cycles, flush in the 2nd
    set_add(5'd2, 5'd3, 5'd4);
    cycle("hf_load");
    frozen = m_ex;
    set_add(5'd5, 5'd6, 5'd7);
    hold = 1;
    cycle("hf_h1");
    check("hf_frozen1", out_w, frozen);
    flush = 1;
    cycle("hf_h2");
    check("hf_frozen2", out_w, frozen);
    flush = 0;
    cycle("hf_h3");
    check("hf_frozen3", out_w, frozen);
    hold = 0;
    cycle("hf_pend");
    check("hf_bubble", out_w.valid, 1'b0);
    cycle("hf_resume");
    check("hf_resume_rd", out_w.rd_addr, 5'd7);

`ifdef ID_EX_PERF_EN
    // counter wrap: preload to all-ones, then one load-use stall
    set_lw(5'd8);
    cycle("wrap_lw");
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_stalls = 32'hFFFF_FFFF;
    set_add(5'd8, 5'd1, 5'd9);
    cycle("wrap_stall");
    check("wrap_cnt", stall_cnt, 32'd0);
`endif

    // randomized traffic with occasional mid-cycle resets
    for (int unsigned i = 0; i < 3000; i++) begin
      randomize_in();
      if ((i % 500) == 499) begin
        #2 rst_n = 0;
        #1 model_reset();
        check_outputs("rnd_rst");
        @(posedge clk); #1;
        rst_n = 1;
      end else begin
        cycle("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
